ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Pixel capture stage that sits directly downstream of `ov7670_controller`. It stays idle until the controller reports `config_finished`. It then locks onto the OV7670 frame timing (`vsync`, `href`, 8-bit `d`) and assembles byte pairs into RGB565 pixels. Each pixel is emitted with its coordinates and a linear frame-buffer address, for the frame buffer / CNN input stage.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `ADDR_W`, 19: width of `pix_addr`; must hold `H_ACTIVE*V_ACTIVE-1`.
- `clk`  in  1  capture clock; driven by camera PCLK at top level; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `config_finished`  in  1  from `ov7670_controller`; level, stays high once set.
- `vsync`  in  1  camera VSYNC; high = vertical blanking.
- `href`  in  1  camera HREF; high = active byte on `d`.
- `d`  in  8  camera data byte.
- `pix_valid`  out  1  one-cycle strobe; pixel outputs valid.
- `pix_data`  out  16  RGB565 pixel, first byte in [15:8].
- `pix_x`  out  $clog2(H_ACTIVE)  column of pixel.
- `pix_y`  out  $clog2(V_ACTIVE)  row of pixel.
- `pix_addr`  out  ADDR_W  linear address, 0 at first pixel of frame.
- `frame_start`  out  1  one-cycle pulse on entering ACTIVE.
- `frame_done`  out  1  one-cycle pulse on leaving ACTIVE via vsync rise.
- `err`  out  1  sticky; cleared only by reset.

## Operation
- Inputs `vsync`, `href` and `d` are registered once on entry (stage S0). All decisions use S0 values. `vsync_q` is the S0 value from the previous cycle.
- FSM states:
  - WAIT_CFG → WAIT_FRAME when `config_finished`=1.
  - WAIT_FRAME → ACTIVE on vsync fall (`vsync_q`=1, vsync=0). Entering ACTIVE clears x, y, addr and byte phase, and pulses `frame_start`.
  - ACTIVE → WAIT_FRAME on vsync rise; pulses `frame_done`.
- The first vsync fall after config is used. A frame already in progress when config finishes is skipped because no fall is seen until the next frame.
- In ACTIVE, each S0 cycle with `href`=1:
  - Phase 0: latch byte as high half, set phase to 1.
  - Phase 1: form pixel {high, d}, emit it, set phase to 0, x+1, addr+1.
- Line end is the `href` fall in ACTIVE: x←0, y+1, phase←0.
  - If phase was 1 at the fall (odd byte count), the partial byte is discarded and `err` is set.
- Bytes with x ≥ `H_ACTIVE`, or lines with y ≥ `V_ACTIVE`, are dropped: no `pix_valid`, `err` set. Counters saturate and never wrap.
- `href` in WAIT_CFG or WAIT_FRAME is ignored.
- Vsync rise mid-line:
  - `frame_done` pulses.
  - Any partial pixel is dropped without setting `err`.
  - State goes to WAIT_FRAME.
- No backpressure: the consumer must accept every `pix_valid`.

## Timing
- Reset values:
  - State WAIT_CFG.
  - `pix_valid`=0, `pix_data`=0, `pix_x`=0, `pix_y`=0, `pix_addr`=0.
  - `frame_start`=0, `frame_done`=0, `err`=0.
  - `vsync_q`=1, phase=0.
- Latency: `pix_valid` is high 2 cycles after the edge that presents the second byte on the pins (1 cycle for S0, 1 cycle for the output register).
- `pix_x` and `pix_y` are the coordinates of the emitted pixel, i.e. the values before increment.
- The maximum pixel rate is one `pix_valid` every 2 cycles. `pix_valid` is never high on consecutive cycles.
- `frame_start` and `frame_done` are registered. They are high 2 cycles after the vsync edge on the pins.
- If `rst_n` is asserted mid-frame, all outputs take their reset values immediately. After release the FSM re-checks `config_finished` and waits for a fresh vsync fall.

## Configuration
- `OV7670_CAPTURE_DECIMATE_EN` defined:
  - Only pixels with even internal x and even internal y assert `pix_valid`.
  - `pix_x` = internal x/2 and `pix_y` = internal y/2.
  - `pix_addr` counts emitted pixels only, reaching `(H_ACTIVE/2)*(V_ACTIVE/2)-1` at the last pixel.
  - Range checks use the internal counters.
- Undefined: every pixel is emitted and `pix_addr` = y*H_ACTIVE + x.

## Test plan
- Hold `config_finished`=0 and drive full frames → no `pix_valid`, no `frame_start`. Raise `config_finished` mid-frame → no output until the next vsync fall.
- Parameters H_ACTIVE=4, V_ACTIVE=2, bytes 0x12,0x34,0x56,0x78… → `pix_data`=0x1234 at (0,0) addr 0, then 0x5678 at (1,0) addr 1. Last pixel at (3,1) addr 7. `frame_done` pulses once and `err`=0.
- Line of 7 bytes (odd) → 3 pixels emitted, `err`=1. Next line starts at x=0 with correct pairing.
- Line of 10 bytes with H_ACTIVE=4 → exactly 4 pixels, `err`=1, `pix_x` never exceeds 3.
- Vsync rise after 3 bytes of line 0 → 1 pixel, then `frame_done`, `err`=0. The next frame restarts at addr 0.
- `OV7670_CAPTURE_DECIMATE_EN` with 4x2 frame → `pix_valid` only for internal (0,0) and (2,0). Outputs show (0,0) addr 0 and (1,0) addr 1.

Source files
------------

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 frame-timing capture stage.
// Waits for config_finished from ov7670_controller, locks onto the camera's
// vsync/href framing and packs byte pairs into RGB565 pixels with their
// coordinates and a linear frame-buffer address.
// Optional feature macro: OV7670_CAPTURE_DECIMATE_EN (2x2 decimation; only
// even-column/even-row pixels are emitted, with halved coordinates and a
// packed address).
`timescale 1ns/1ps

module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        config_finished,
    input  logic                        vsync,
    input  logic                        href,
    input  logic [7:0]                  d,
    output logic                        pix_valid,
    output logic [15:0]                 pix_data,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    output logic [ADDR_W-1:0]           pix_addr,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        err
);

    localparam int X_W  = $clog2(H_ACTIVE);
    localparam int Y_W  = $clog2(V_ACTIVE);
    // Internal counters are one value wider than the coordinates so they can
    // sit at H_ACTIVE / V_ACTIVE (saturated, "out of range") without wrapping.
    localparam int XC_W = $clog2(H_ACTIVE + 1);
    localparam int YC_W = $clog2(V_ACTIVE + 1);
    localparam logic [XC_W-1:0] X_LIMIT = XC_W'(H_ACTIVE);
    localparam logic [YC_W-1:0] Y_LIMIT = YC_W'(V_ACTIVE);

    localparam logic [1:0] ST_WAIT_CFG   = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_ACTIVE     = 2'd2;

    // S0 input registers and previous-cycle copies for edge detection
    logic       vsync_s0;
    logic       href_s0;
    logic [7:0] d_s0;
    logic       vsync_q;
    logic       href_q;

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic [XC_W-1:0] x_cnt;
    logic [YC_W-1:0] y_cnt;
    logic            phase;
    logic [7:0]      hi_byte;

`ifdef OV7670_CAPTURE_DECIMATE_EN
    logic [ADDR_W-1:0] emit_cnt;
`else
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    logic [ADDR_W-1:0] line_base;
`endif

    logic vsync_fall;
    logic vsync_rise;
    logic enter_active;
    logic leave_active;
    logic capture;
    logic in_range;
    logic byte_ok;
    logic byte_drop;
    logic line_end;
    logic pixel_done;
    logic pix_emit;

    assign vsync_fall   = vsync_q & ~vsync_s0;
    assign vsync_rise   = ~vsync_q & vsync_s0;
    assign enter_active = (state == ST_WAIT_FRAME) && vsync_fall;
    assign leave_active = (state == ST_ACTIVE) && vsync_rise;
    // A vsync rise wins over any href activity in the same cycle, so a line
    // cut short by the end of frame never flags an error.
    assign capture      = (state == ST_ACTIVE) && !vsync_rise;
    assign in_range     = (x_cnt < X_LIMIT) && (y_cnt < Y_LIMIT);
    assign byte_ok      = capture && href_s0 && in_range;
    assign byte_drop    = capture && href_s0 && !in_range;
    assign line_end     = capture && !href_s0 && href_q;
    assign pixel_done   = byte_ok && phase;

`ifdef OV7670_CAPTURE_DECIMATE_EN
    assign pix_emit = pixel_done && !x_cnt[0] && !y_cnt[0];
`else
    assign pix_emit = pixel_done;
`endif

    // Register camera pins once (S0) and keep last S0 values for edges
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; the async reset branch gives known values without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // vsync_s0 resets low while vsync_q resets high: the first sample
            // after reset lands in WAIT_CFG, so a vsync already low mid-frame
            // cannot masquerade as a fresh falling edge.
            vsync_s0 <= 1'b0;
            href_s0  <= 1'b0;
            d_s0     <= 8'h00;
            vsync_q  <= 1'b1;
            href_q   <= 1'b0;
        end else begin
            vsync_s0 <= vsync;
            href_s0  <= href;
            d_s0     <= d;
            vsync_q  <= vsync_s0;
            href_q   <= href_s0;
        end
    end

    // Next-state logic: config gate, then frame lock on vsync edges
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_CFG:   if (config_finished) state_nxt = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (vsync_fall)      state_nxt = ST_ACTIVE;
            ST_ACTIVE:     if (vsync_rise)      state_nxt = ST_WAIT_FRAME;
            default:                            state_nxt = ST_WAIT_CFG;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_CFG;
        end else begin
            state <= state_nxt;
        end
    end

    // Position counters and byte-pair assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            phase     <= 1'b0;
            hi_byte   <= 8'h00;
`ifdef OV7670_CAPTURE_DECIMATE_EN
            emit_cnt  <= '0;
`else
            line_base <= '0;
`endif
        end else if (enter_active) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            phase     <= 1'b0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
            emit_cnt  <= '0;
`else
            line_base <= '0;
`endif
        end else if (leave_active) begin
            // Partial pixel at end of frame is silently discarded.
            phase <= 1'b0;
        end else if (byte_ok) begin
            if (!phase) begin
                hi_byte <= d_s0;
                phase   <= 1'b1;
            end else begin
                phase <= 1'b0;
                x_cnt <= x_cnt + XC_W'(1);
`ifdef OV7670_CAPTURE_DECIMATE_EN
                if (pix_emit) emit_cnt <= emit_cnt + ADDR_W'(1);
`endif
            end
        end else if (line_end) begin
            x_cnt <= '0;
            phase <= 1'b0;
            if (y_cnt < Y_LIMIT) begin
                y_cnt <= y_cnt + YC_W'(1);
`ifndef OV7670_CAPTURE_DECIMATE_EN
                line_base <= line_base + LINE_STEP;
`endif
            end
        end
    end

    // Registered pixel outputs, frame pulses and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= 16'h0000;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_addr    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            pix_valid   <= pix_emit;
            frame_start <= enter_active;
            frame_done  <= leave_active;
            if (byte_drop || (line_end && phase)) begin
                err <= 1'b1;
            end
            if (pix_emit) begin
                pix_data <= {hi_byte, d_s0};
`ifdef OV7670_CAPTURE_DECIMATE_EN
                pix_x    <= X_W'(x_cnt >> 1);
                pix_y    <= Y_W'(y_cnt >> 1);
                pix_addr <= emit_cnt;
`else
                pix_x    <= X_W'(x_cnt);
                pix_y    <= Y_W'(y_cnt);
                pix_addr <= line_base + ADDR_W'(x_cnt);
`endif
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: scoreboard bench for ov7670_capture on a 4x2 frame.
// Expected pixels are pushed when bytes are driven and compared against the
// pixels the monitor collects. Honours OV7670_CAPTURE_DECIMATE_EN.
`timescale 1ns/1ps

module tb_ov7670_capture;

    localparam int TB_H  = 4;
    localparam int TB_V  = 2;
    localparam int TB_AW = 3;
    localparam int XW    = $clog2(TB_H);
    localparam int YW    = $clog2(TB_V);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            config_finished = 1'b0;
    logic            vsync = 1'b1;
    logic            href = 1'b0;
    logic [7:0]      d = 8'h00;
    logic            pix_valid;
    logic [15:0]     pix_data;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic [TB_AW-1:0] pix_addr;
    logic            frame_start;
    logic            frame_done;
    logic            err;

    ov7670_capture #(
        .H_ACTIVE(TB_H),
        .V_ACTIVE(TB_V),
        .ADDR_W  (TB_AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_finished(config_finished),
        .vsync          (vsync),
        .href           (href),
        .d              (d),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_addr       (pix_addr),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      data;
        logic [XW-1:0]    x;
        logic [YW-1:0]    y;
        logic [TB_AW-1:0] addr;
        logic [31:0]      cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t obs_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int          fs_cnt  = 0;
    int          fd_cnt  = 0;
    int unsigned fs_cyc  = 0;
    int unsigned fall_cyc = 0;
    bit          consec_seen = 0;
    int          max_x = 0;
    logic        prev_valid = 1'b0;

    // Reference model state
    bit         m_cap  = 0;
    bit         m_err  = 0;
    int         m_x    = 0;
    int         m_y    = 0;
    int         m_emit = 0;
    logic [7:0] nb     = 8'h12;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect emitted pixels and frame pulses away from the active edge
    always @(negedge clk) begin : monitor
        pix_t p;
        if (pix_valid) begin
            p = {pix_data, pix_x, pix_y, pix_addr, cyc};
            obs_q.push_back(p);
            if (prev_valid) consec_seen = 1;
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
        end
        prev_valid = pix_valid;
        if (frame_start) begin
            fs_cnt++;
            fs_cyc = cyc;
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        href  = 1'b0;
        vsync = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        obs_q.delete();
        exp_q.delete();
        m_err = 0;
    endtask

    // Model: record the pixel the DUT must emit for the pair just completed
    task automatic push_pixel(input logic [15:0] px);
        pix_t e;
`ifdef OV7670_CAPTURE_DECIMATE_EN
        if ((m_x % 2 == 0) && (m_y % 2 == 0)) begin
            e = {px, XW'(m_x / 2), YW'(m_y / 2), TB_AW'(m_emit), 32'(cyc + 2)};
            exp_q.push_back(e);
            m_emit++;
        end
`else
        e = {px, XW'(m_x), YW'(m_y), TB_AW'(m_y * TB_H + m_x), 32'(cyc + 2)};
        exp_q.push_back(e);
`endif
    endtask

    // Drive one href line of nbytes; abort ends it with a vsync rise instead
    task automatic send_line(input int nbytes, input bit abort = 0);
        bit         phase = 0;
        logic [7:0] hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            d    = nb;
            if (m_cap) begin
                if (m_x >= TB_H || m_y >= TB_V) begin
                    m_err = 1;
                end else if (!phase) begin
                    hi    = nb;
                    phase = 1;
                end else begin
                    phase = 0;
                    push_pixel({hi, nb});
                    m_x++;
                end
            end
            nb = nb + 8'h22;
            tick();
        end
        href = 1'b0;
        d    = 8'h00;
        if (abort) begin
            vsync = 1'b1;
        end else if (m_cap) begin
            if (phase) m_err = 1;
            m_x = 0;
            if (m_y < TB_V) m_y++;
        end
        repeat (3) tick();
    endtask

    task automatic frame_open();
        vsync = 1'b1;
        repeat (4) tick();
        vsync    = 1'b0;
        fall_cyc = cyc;
        if (m_cap) begin
            m_x = 0;
            m_y = 0;
            m_emit = 0;
        end
        repeat (3) tick();
    endtask

    task automatic frame_close();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    // Scoreboard drain: pair observed pixels with expected ones
    task automatic check_pixels(input string name);
        pix_t o;
        pix_t e;
        int   k = 0;
        repeat (4) tick();
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s pixel_count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s pixel[%0d]: got data=%h x=%0d y=%0d addr=%0d cyc=%0d, expected data=%h x=%0d y=%0d addr=%0d cyc=%0d",
                         name, k, o.data, o.x, o.y, o.addr, o.cyc, e.data, e.x, e.y, e.addr, e.cyc);
            end
            k++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        tick();
        n_tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_start, frame_done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h x=%0d y=%0d addr=%0d fs=%b fd=%b err=%b, expected all 0",
                     pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_start, frame_done, err);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({pix_valid, frame_start, frame_done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got valid=%b fs=%b fd=%b err=%b, expected 0000",
                     pix_valid, frame_start, frame_done, err);
        end
    endtask

    task automatic test_no_config();
        int fs0 = fs_cnt;
        int fd0 = fd_cnt;
        m_cap = 0;
        frame_open();
        send_line(8);
        send_line(8);
        frame_close();
        n_tests++;
        if (obs_q.size() !== 0 || fs_cnt !== fs0) begin
            n_fail++;
            $display("FAIL no_config_frame: got pixels=%0d frame_starts=%0d, expected 0 and 0",
                     obs_q.size(), fs_cnt - fs0);
        end
        // Config completes in the middle of a frame: that frame is skipped
        frame_open();
        send_line(8);
        config_finished = 1'b1;
        send_line(8);
        frame_close();
        repeat (3) tick();
        n_tests++;
        if (obs_q.size() !== 0 || fs_cnt !== fs0 || fd_cnt !== fd0) begin
            n_fail++;
            $display("FAIL config_mid_frame: got pixels=%0d fs=%0d fd=%0d, expected 0 0 0",
                     obs_q.size(), fs_cnt - fs0, fd_cnt - fd0);
        end
        obs_q.delete();
    endtask

    task automatic test_basic();
        int fs0 = fs_cnt;
        int fd0 = fd_cnt;
        m_cap = 1;
        nb    = 8'h12;
        frame_open();
        n_tests++;
        if (fs_cnt !== fs0 + 1 || fs_cyc !== fall_cyc + 2) begin
            n_fail++;
            $display("FAIL frame_start_timing: got count=%0d at cyc %0d, expected 1 at cyc %0d",
                     fs_cnt - fs0, fs_cyc, fall_cyc + 2);
        end
        send_line(8);
        send_line(8);
        frame_close();
        check_pixels("basic");
        n_tests++;
        if (fd_cnt !== fd0 + 1) begin
            n_fail++;
            $display("FAIL basic_frame_done: got %0d pulses, expected 1", fd_cnt - fd0);
        end
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL basic_err: got %b, expected %b", err, m_err);
        end
    endtask

    task automatic test_odd_line();
        apply_reset();
        nb = 8'h12;
        frame_open();
        send_line(7);
        send_line(8);
        frame_close();
        check_pixels("odd_line");
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL odd_line_err: got %b, expected %b", err, m_err);
        end
    endtask

    task automatic test_long_line();
        apply_reset();
        nb = 8'h40;
        frame_open();
        send_line(10);
        send_line(8);
        frame_close();
        check_pixels("long_line");
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL long_line_err: got %b, expected %b", err, m_err);
        end
        n_tests++;
        if (max_x > TB_H - 1) begin
            n_fail++;
            $display("FAIL long_line_max_x: got %0d, expected at most %0d", max_x, TB_H - 1);
        end
    endtask

    task automatic test_abort();
        int fd0;
        apply_reset();
        fd0 = fd_cnt;
        nb  = 8'h12;
        frame_open();
        send_line(3, 1);
        repeat (2) tick();
        n_tests++;
        if (fd_cnt !== fd0 + 1) begin
            n_fail++;
            $display("FAIL abort_frame_done: got %0d pulses, expected 1", fd_cnt - fd0);
        end
        check_pixels("abort");
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL abort_err: got %b, expected %b", err, m_err);
        end
        // The next frame restarts at address 0
        frame_open();
        send_line(8);
        send_line(8);
        frame_close();
        check_pixels("after_abort");
        n_tests++;
        if (fd_cnt !== fd0 + 2 || err !== m_err) begin
            n_fail++;
            $display("FAIL after_abort_status: got fd=%0d err=%b, expected fd=2 err=%b",
                     fd_cnt - fd0, err, m_err);
        end
    endtask

    task automatic test_reset_midframe();
        int fs0;
        int fd0;
        m_cap = 0;
        nb    = 8'h55;
        frame_open();
        send_line(8);
        for (int i = 0; i < 3; i++) begin
            href = 1'b1;
            d    = nb;
            nb   = nb + 8'h22;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_start, frame_done, err} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got valid=%b data=%h x=%0d y=%0d addr=%0d fs=%b fd=%b err=%b, expected all 0",
                     pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_start, frame_done, err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        m_err = 0;
        obs_q.delete();
        exp_q.delete();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        // Rest of the interrupted frame must be ignored
        send_line(5);
        send_line(8);
        frame_close();
        n_tests++;
        if (obs_q.size() !== 0 || fs_cnt !== fs0 || fd_cnt !== fd0) begin
            n_fail++;
            $display("FAIL midframe_resync: got pixels=%0d fs=%0d fd=%0d, expected 0 0 0",
                     obs_q.size(), fs_cnt - fs0, fd_cnt - fd0);
        end
        obs_q.delete();
        m_cap = 1;
        nb    = 8'h12;
        frame_open();
        send_line(8);
        send_line(8);
        frame_close();
        check_pixels("after_midframe_reset");
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL after_midframe_reset_err: got %b, expected %b", err, m_err);
        end
    endtask

    task automatic test_pixel_rate();
        n_tests++;
        if (consec_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL pixel_rate: got pix_valid on consecutive cycles, expected never");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_no_config();
        test_basic();
        test_odd_line();
        test_long_line();
        test_abort();
        test_reset_midframe();
        test_pixel_rate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
